// File: rtl/stream_upsize_pkg.sv
// Shared types and width helpers for the packet-aware narrow-to-wide stream upsizer.
package stream_upsize_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DATA_RATIO = 4;
    localparam int DEF_OUT_DEPTH  = 2;

    localparam int IDX_W = $clog2(DEF_DATA_RATIO);
    localparam int CNT_W = $clog2(DEF_OUT_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_DATA_RATIO-1:0][DEF_DATA_WIDTH-1:0] lanes;
        logic [DEF_DATA_RATIO-1:0]                     keep;
        logic                                          last;
    } upsize_word_t;

    function automatic int idx_width(input int ratio);
        return $clog2(ratio);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/flip_flop_fifo.sv
// Small register-based FIFO; head entry is always visible on head_data.
module flip_flop_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Full pushes and empty pops are ignored so the occupancy can never wrap.
    assign do_push   = push & (count != CW'(DEPTH));
    assign do_pop    = pop & (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/stream_upsize_pkt.sv
// Packs narrow beats into wide words with per-lane keep, closing words on last,
// on a full lane set, or on flush; completed words wait in a small output FIFO.
module stream_upsize_pkt
    import stream_upsize_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4,
    parameter int OUT_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic                    flush_i,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int IW     = idx_width(T_DATA_RATIO);
    localparam int CW     = cnt_width(OUT_DEPTH);
    localparam int WORD_W = T_DATA_WIDTH * T_DATA_RATIO + T_DATA_RATIO + 1;

    logic [IW-1:0]                               idx;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0]   lanes;
    logic [T_DATA_RATIO-1:0]                     acc_keep;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0]   next_lanes;
    logic [T_DATA_RATIO-1:0]                     next_keep;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0]   head_lanes;
    logic [CW-1:0]                               fifo_count;
    logic [WORD_W-1:0]                           push_word;
    logic [WORD_W-1:0]                           head_word;
    logic                                        fifo_full;
    logic                                        s_hs;
    logic                                        word_done;
    logic                                        flush_only;
    logic                                        push;
    logic                                        pop;

    // Ready depends only on the registered occupancy, never on m_ready_i.
    assign fifo_full  = (fifo_count == CW'(OUT_DEPTH));
    assign s_ready_o  = ~rst & ~fifo_full;
    assign s_hs       = s_valid_i & s_ready_o;
    assign word_done  = s_hs & ((idx == IW'(T_DATA_RATIO - 1)) | s_last_i | flush_i);
    assign flush_only = ~s_hs & flush_i & (acc_keep != '0) & ~fifo_full;
    assign push       = word_done | flush_only;
    assign pop        = m_valid_o & m_ready_i;

    always_comb begin
        next_lanes = lanes;
        next_keep  = acc_keep;
        if (s_hs) begin
            next_lanes[idx] = s_data_i;
            next_keep[idx]  = 1'b1;
        end
    end

    assign push_word = {next_lanes, next_keep, word_done & s_last_i};

    // Cleared lanes after each push make unwritten lanes of the next word read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            lanes    <= '0;
            acc_keep <= '0;
        end else if (push) begin
            idx      <= '0;
            lanes    <= '0;
            acc_keep <= '0;
        end else if (s_hs) begin
            idx      <= idx + IW'(1);
            lanes    <= next_lanes;
            acc_keep <= next_keep;
        end
    end

    flip_flop_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head_data (head_word),
        .count     (fifo_count)
    );

    assign m_valid_o  = (fifo_count != '0);
    assign head_lanes = head_word[WORD_W-1 -: T_DATA_WIDTH*T_DATA_RATIO];
    assign m_keep_o   = m_valid_o ? head_word[T_DATA_RATIO:1] : '0;
    assign m_last_o   = m_valid_o & head_word[0];

    always_comb begin
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            m_data_o[i] = m_valid_o ? head_lanes[i] : '0;
        end
    end

endmodule

// File: tb/tb_stream_upsize_pkt.sv
// Randomized and directed bench for stream_upsize_pkt against a queue-based packet model.
module tb_stream_upsize_pkt;
    import stream_upsize_pkg::*;

    localparam int W = DEF_DATA_WIDTH;
    localparam int R = DEF_DATA_RATIO;
    localparam int D = DEF_OUT_DEPTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] s_data_i = '0;
    logic         s_last_i = 1'b0;
    logic         s_valid_i = 1'b0;
    logic         s_ready_o;
    logic         flush_i = 1'b0;
    logic [W-1:0] m_data_o [R-1:0];
    logic [R-1:0] m_keep_o;
    logic         m_last_o;
    logic         m_valid_o;
    logic         m_ready_i = 1'b0;

    int errors = 0;
    int checks = 0;

    upsize_word_t exp_q[$];
    logic [W-1:0] asm_q[$];
    bit           last_hs;

    always #5 clk = ~clk;

    stream_upsize_pkt #(
        .T_DATA_WIDTH (W),
        .T_DATA_RATIO (R),
        .OUT_DEPTH    (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .flush_i   (flush_i),
        .m_data_o  (m_data_o),
        .m_keep_o  (m_keep_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic upsize_word_t makeWord(input logic last);
        upsize_word_t w;
        w = '0;
        foreach (asm_q[i]) begin
            w.lanes[i] = asm_q[i];
            w.keep[i]  = 1'b1;
        end
        w.last = last;
        return w;
    endfunction

    task automatic compareOutputs();
        upsize_word_t h;
        h = (exp_q.size() != 0) ? exp_q[0] : '0;
        checkOutput("s_ready", 32'(s_ready_o), 32'(!rst && exp_q.size() < D));
        checkOutput("m_valid", 32'(m_valid_o), 32'(exp_q.size() != 0));
        checkOutput("m_keep", 32'(m_keep_o), 32'(h.keep));
        checkOutput("m_last", 32'(m_last_o), 32'(h.last));
        for (int i = 0; i < R; i++) begin
            checkOutput($sformatf("m_data[%0d]", i), 32'(m_data_o[i]), 32'(h.lanes[i]));
        end
    endtask

    // One clock of stimulus: model decisions use the state seen before the edge.
    task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit l,
                                 input bit f, input bit r, input bit rs);
        bit           ready;
        bit           hs;
        bit           pop;
        bit           have;
        upsize_word_t w;
        s_valid_i = v;
        s_data_i  = d;
        s_last_i  = l;
        flush_i   = f;
        m_ready_i = r;
        rst       = rs;
        ready = !rs && (exp_q.size() < D);
        hs    = v && ready;
        pop   = (exp_q.size() != 0) && r;
        have  = 1'b0;
        w     = '0;
        if (hs) begin
            asm_q.push_back(d);
            if (asm_q.size() == R || l || f) begin
                w    = makeWord(l);
                have = 1'b1;
                asm_q.delete();
            end
        end else if (f && asm_q.size() != 0 && exp_q.size() < D) begin
            w    = makeWord(1'b0);
            have = 1'b1;
            asm_q.delete();
        end
        if (pop) void'(exp_q.pop_front());
        if (have) exp_q.push_back(w);
        if (rs) begin
            exp_q.delete();
            asm_q.delete();
        end
        last_hs = hs;
        @(posedge clk);
        #1;
        compareOutputs();
    endtask

    task automatic sendBeat(input logic [W-1:0] d, input bit l, input bit f, input bit r);
        int tries = 0;
        do begin
            applyStimulus(1'b1, d, l, f, r, 1'b0);
            tries++;
        end while (!last_hs && tries < 64);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, r, 1'b0);
    endtask

    initial begin
        int k;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);

        for (int i = 1; i <= 8; i++) sendBeat(W'(i), i == 8, 1'b0, 1'b1);
        idle(3, 1'b1);

        sendBeat(8'hA1, 1'b0, 1'b0, 1'b1);
        sendBeat(8'hA2, 1'b0, 1'b0, 1'b1);
        sendBeat(8'hA3, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        sendBeat(8'hB1, 1'b0, 1'b0, 1'b1);
        sendBeat(8'hB2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        sendBeat(8'hC1, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Downstream stalled while a 16-beat packet is offered, then released.
        k = 0;
        for (int c = 0; c < 14; c++) begin
            applyStimulus(1'b1, W'(8'h10 + k), 1'b0, 1'b0, 1'b0, 1'b0);
            if (last_hs) k++;
        end
        while (k < 16) begin
            sendBeat(W'(8'h10 + k), k == 15, 1'b0, 1'b1);
            k++;
        end
        idle(4, 1'b1);

        sendBeat(8'hD1, 1'b0, 1'b0, 1'b1);
        sendBeat(8'hD2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);
        sendBeat(8'hE1, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, W'($urandom_range(0, 255)),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        end
        idle(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
